load_store_unit: RTL
====================

# load_store_unit

Memory-access front end of the MIPS pipeline, sitting directly upstream of the write-back/data-memory stage. It accepts one load or store request at a time and drives the word-wide data-memory port: `dataAddress`, `writeMemData`, `memRead` and `memWrite`. It implements byte and halfword loads (with sign or zero extension), byte and halfword stores (via read-modify-write), word accesses and misalignment detection. It returns one registered response per request.

## Interface
- `LOG_DEPTH_MEM`, default 10: log2 of data-memory depth in 32-bit words; equals `` `logDepthMem``.
- `WIDTH`, default 32: data width; fixed at 32 (four little-endian byte lanes).

- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit idle, able to accept; a request is accepted when `req_valid & req_ready`.
- `req_store` input 1: 1 = store, 0 = load.
- `req_size` input 3: load codes are 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Store codes are 0 sb, 1 sh, 2 sw. All other codes are illegal.
- `req_addr` input WIDTH: byte address.
- `req_wdata` input WIDTH: store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- `resp_valid` output 1: one-cycle response pulse.
- `resp_rdata` output WIDTH: extended load result; 0 for stores and errors.
- `resp_err` output 1: misaligned address or illegal code; qualified by `resp_valid`.
- `dataAddress` output LOG_DEPTH_MEM: word index, equal to `req_addr[LOG_DEPTH_MEM+1:2]`. Upper address bits are ignored, so addresses wrap.
- `writeMemData` output WIDTH: word to write.
- `memRead` output 1: read strobe.
- `memWrite` output 1: write strobe.
- `readMemData` input WIDTH: memory read data, valid the cycle after `memRead` is high (registered read).

## Operation
- On accept, the unit latches `req_store`, `req_size`, `req_addr` and `req_wdata`. Inputs are ignored while `req_ready` = 0, and the requester holds them.
- FSM states are IDLE, RD, CAP, MRG, WR and RESP.
  - IDLE: `req_ready` = 1. On accept, the next state is:
    - RESP, flagged as an error, if the request is illegal or misaligned;
    - RD for loads;
    - WR for sw;
    - RD for sb and sh (read-modify-write).
  - RD: `memRead` = 1, then go to CAP.
  - CAP, for loads: capture `readMemData`, select lane by `addr[1:0]` (byte) or `addr[1]` (half), extend, register into `resp_rdata`, then go to RESP.
  - CAP, for sb and sh: capture the word into a merge register, then go to MRG.
  - MRG: replace the addressed byte or half with `req_wdata` low bits, then go to WR.
  - WR: `memWrite` = 1 and `writeMemData` = the full sw word or the merged word, then go to RESP.
  - RESP: `resp_valid` = 1 for exactly one cycle, then go to IDLE.
- Misalignment rules:
  - lh, lhu and sh are misaligned when `addr[0]` = 1.
  - lw and sw are misaligned when `addr[1:0]` ≠ 0.
  - Byte accesses are never misaligned.
  - Erroneous requests perform no memory access and return `resp_rdata` = 0.
- Extension rules:
  - lb and lh sign-extend from bit 7 or bit 15 of the selected lane.
  - lbu and lhu zero-extend.
- Outputs outside their active states:
  - `dataAddress` holds the latched index from RD through WR and is 0 in IDLE and RESP.
  - `writeMemData` is 0 outside WR.
- Reset, including mid-operation:
  - State goes to IDLE immediately, and `memRead` and `memWrite` drop asynchronously.
  - The merge register and latched request clear.
  - An aborted read-modify-write never writes.
- Reset values:
  - `req_ready` = 1.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0.
  - `dataAddress` = 0, `writeMemData` = 0, `memRead` = 0, `memWrite` = 0.

## Timing
- The request is accepted at the edge ending cycle T. Response timing by request type:
  - Error: `resp_valid` in T+1.
  - sw: `memWrite` in T+1, `resp_valid` in T+2.
  - Load: `memRead` in T+1, data sampled in T+2, `resp_valid` in T+3.
  - sb/sh: `memRead` in T+1, capture in T+2, merge in T+3, `memWrite` in T+4, `resp_valid` in T+5.
- `req_ready` returns to 1 in the cycle after RESP. There is no response/accept overlap, so the maximum rate is one request per (latency + 1) cycles.
- `memRead` and `memWrite` are never high in the same cycle; each is high for exactly one cycle per access.

## Test plan
- Preload word 5 = 0x8899AABB. Issue lb at 0x14 → `memRead` in T+1 with `dataAddress` = 5, `resp_rdata` = 0xFFFFFFBB in T+3, `resp_err` = 0.
- Same memory contents: lbu at 0x17 gives 0x00000088, lh at 0x16 gives 0xFFFF8899, lhu at 0x14 gives 0x0000AABB, lw at 0x14 gives 0x8899AABB.
- sh at 0x16 with `req_wdata` = 0x00001234 → `memWrite` in T+4 with `writeMemData` = 0x1234AABB; a following lw at 0x14 returns 0x1234AABB. sb at 0x15 with data 0x77 → 0x1234 77BB, i.e. 0x123477BB.
- lw at 0x15, sh at 0x13, and `req_size` = 3 → `resp_err` = 1 in T+1 with `resp_rdata` = 0; `memRead` and `memWrite` never assert.
- Assert `rst` in T+2 of an sb → `memWrite` never asserts, memory word is unchanged, all outputs return to reset values, and `req_ready` = 1 after release.
- Hold `req_valid` high with changing inputs while busy → only the accepted request is executed; the next request is accepted only in the cycle after `resp_valid`.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store front end for the data-memory port: byte/half/word loads with extension,
// byte/half stores by read-modify-write, misalignment and illegal-code detection.
module load_store_unit #(
    parameter int LOG_DEPTH_MEM = 10,
    parameter int WIDTH         = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [2:0]               req_size,
    input  logic [WIDTH-1:0]         req_addr,
    input  logic [WIDTH-1:0]         req_wdata,
    output logic                     resp_valid,
    output logic [WIDTH-1:0]         resp_rdata,
    output logic                     resp_err,
    output logic [LOG_DEPTH_MEM-1:0] dataAddress,
    output logic [WIDTH-1:0]         writeMemData,
    output logic                     memRead,
    output logic                     memWrite,
    input  logic [WIDTH-1:0]         readMemData
);

    // state | meaning
    // IDLE  | ready for a request
    // RD    | read strobe for load or read-modify-write
    // CAP   | capture read word (load result or merge base)
    // MRG   | splice store byte/half into merge word
    // WR    | write strobe
    // RESP  | one-cycle response
    typedef enum logic [2:0] {IDLE, RD, CAP, MRG, WR, RESP} state_e;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;
    localparam int         AW    = LOG_DEPTH_MEM + 2;

    state_e            state_q, state_d;
    logic              store_q;
    logic [2:0]        size_q;
    logic [AW-1:0]     addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  merge_q, merge_d;
    logic [WIDTH-1:0]  rdata_q;
    logic [WIDTH-1:0]  load_ext;
    logic              err_q;
    logic              accept;
    logic              size_ok;
    logic              misal;
    logic              req_bad;
    logic              unused_addr_hi;

    // Upper address bits wrap and are deliberately dropped.
    assign unused_addr_hi = ^req_addr[WIDTH-1:AW];

    assign accept = req_valid && (state_q == IDLE);

    always_comb begin
        size_ok = 1'b0;
        if (req_store) begin
            size_ok = (req_size == SZ_B) || (req_size == SZ_H) || (req_size == SZ_W);
        end else begin
            size_ok = (req_size == SZ_B) || (req_size == SZ_H) || (req_size == SZ_W)
                   || (req_size == SZ_BU) || (req_size == SZ_HU);
        end
        misal = 1'b0;
        case (req_size[1:0])
            2'd1:    misal = req_addr[0];
            2'd2:    misal = (req_addr[1:0] != 2'd0);
            default: misal = 1'b0;
        endcase
        req_bad = !size_ok || misal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad)                          state_d = RESP;
                    else if (req_store && req_size == SZ_W) state_d = WR;
                    else                                  state_d = RD;
                end
            end
            RD:      state_d = CAP;
            CAP:     state_d = store_q ? MRG : RESP;
            MRG:     state_d = WR;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ext = readMemData;
        case (size_q)
            SZ_B, SZ_BU: begin
                logic [7:0] b;
                case (addr_q[1:0])
                    2'd0:    b = readMemData[7:0];
                    2'd1:    b = readMemData[15:8];
                    2'd2:    b = readMemData[23:16];
                    default: b = readMemData[31:24];
                endcase
                load_ext = {{(WIDTH-8){(size_q == SZ_B) & b[7]}}, b};
            end
            SZ_H, SZ_HU: begin
                logic [15:0] h;
                h = addr_q[1] ? readMemData[31:16] : readMemData[15:0];
                load_ext = {{(WIDTH-16){(size_q == SZ_H) & h[15]}}, h};
            end
            default: load_ext = readMemData;
        endcase
    end

    always_comb begin
        merge_d = merge_q;
        if (size_q == SZ_B) begin
            case (addr_q[1:0])
                2'd0:    merge_d[7:0]   = wdata_q[7:0];
                2'd1:    merge_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_d[23:16] = wdata_q[7:0];
                default: merge_d[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merge_d[31:16] = wdata_q[15:0];
        end else begin
            merge_d[15:0] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                store_q <= req_store;
                size_q  <= req_size;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= req_bad;
            end
            if (state_q == CAP) begin
                if (store_q) merge_q <= readMemData;
                else         rdata_q <= load_ext;
            end
            if (state_q == MRG) merge_q <= merge_d;
        end
    end

    always_comb begin
        req_ready    = (state_q == IDLE);
        memRead      = (state_q == RD);
        memWrite     = (state_q == WR);
        resp_valid   = (state_q == RESP);
        resp_err     = (state_q == RESP) && err_q;
        resp_rdata   = rdata_q;
        dataAddress  = '0;
        writeMemData = '0;
        if (state_q == RD || state_q == CAP || state_q == MRG || state_q == WR)
            dataAddress = addr_q[AW-1:2];
        if (state_q == WR)
            writeMemData = (size_q == SZ_W) ? wdata_q : merge_q;
    end

endmodule
